// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / SERVE_IF / SERVE_D)
//   ADDR_W, DATA_W, INSTR_W : address, data and instruction widths
package mem_arb_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_D  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_wait_timer.sv
// Clearable, saturating up-counter with a terminal-count look-ahead flag.
// Used as the bus timeout counter and as the optional wait-cycle counters.
//   clk, reset : clock and synchronous active-high reset (count -> 0)
//   clear      : synchronous clear, has priority over inc
//   inc        : increment by one (holds at all-ones)
//   count      : current count
//   last       : one more increment reaches TERMINAL (never set if TERMINAL = 0)
module arb_wait_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TERMINAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  localparam logic [WIDTH:0] TERM = (WIDTH+1)'(TERMINAL);

  logic [WIDTH:0] count_p1;

  assign count_p1 = {1'b0, count} + (WIDTH+1)'(1);
  assign last     = (TERMINAL != 0) && (count_p1 == TERM);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and data
// access (MEM). One transaction at a time over mem_req/mem_ack; data has
// priority, bounded by MAX_DATA_STREAK while a fetch waits; a transaction
// with no mem_ack within TIMEOUT_CYCLES (0 = never) completes with err.
//   if_req/if_addr -> if_rdata/if_done        : fetch port
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_done : data port
//   err   : pulses with the done of a timed-out transaction
//   mem_* : memory side;  busy : FSM not in IDLE
//   perf_if_wait/perf_d_wait : wait-cycle counters, built only when the
//   macro ARB_PERF_CNT_EN is defined, otherwise tied to 0.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic [INSTR_W-1:0] if_rdata,
  output logic               if_done,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               d_done,
  output logic               err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic               busy,
  output logic [31:0]        perf_if_wait,
  output logic [31:0]        perf_d_wait
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  arb_state_e state;
  logic [3:0] streak;
  logic       if_req_eff, d_req_eff, streak_hit, grant_d, grant_if;
  logic       serving, tmo_last, tmo_fire;
  logic [7:0] tmo_count_unused;

  // A requester whose done is showing has a stale req this cycle; mask it.
  assign if_req_eff = if_req & ~if_done;
  assign d_req_eff  = d_req & ~d_done;
  assign streak_hit = if_req_eff && (streak == STREAK_MAX);
  assign grant_d    = (state == IDLE) && d_req_eff && !streak_hit;
  assign grant_if   = (state == IDLE) && if_req_eff && !grant_d;
  assign serving    = (state != IDLE);
  assign busy       = serving;
  assign tmo_fire   = serving && !mem_ack && tmo_last;

  arb_wait_timer #(
    .WIDTH   (8),
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk  (clk),
    .reset(reset),
    .clear(!serving),
    .inc  (serving && !mem_ack),
    .count(tmo_count_unused),
    .last (tmo_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      d_rdata   <= '0;
      d_done    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= SERVE_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!if_req_eff)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + 4'd1;
          end else if (grant_if) begin
            state     <= SERVE_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            streak    <= '0;
          end
        end
        SERVE_IF: begin
          if (mem_ack || tmo_fire) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            if_done  <= 1'b1;
            err      <= !mem_ack;
            if_rdata <= mem_ack ? mem_rdata[INSTR_W-1:0] : '0;
          end
        end
        SERVE_D: begin
          if (mem_ack || tmo_fire) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            d_done  <= 1'b1;
            err     <= !mem_ack;
            if (!mem_ack)
              d_rdata <= '0;
            else if (!mem_we)
              d_rdata <= mem_rdata;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic perf_if_last_unused, perf_d_last_unused;

  arb_wait_timer #(
    .WIDTH   (32),
    .TERMINAL(0)
  ) u_perf_if (
    .clk  (clk),
    .reset(reset),
    .clear(1'b0),
    .inc  (if_req && (state != SERVE_IF)),
    .count(perf_if_wait),
    .last (perf_if_last_unused)
  );

  arb_wait_timer #(
    .WIDTH   (32),
    .TERMINAL(0)
  ) u_perf_d (
    .clk  (clk),
    .reset(reset),
    .clear(1'b0),
    .inc  (d_req && (state != SERVE_D)),
    .count(perf_d_wait),
    .last (perf_d_last_unused)
  );
`else
  assign perf_if_wait = '0;
  assign perf_d_wait  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, scoreboard-checked bench for mem_port_arbiter (default parameters:
// MAX_DATA_STREAK = 4, TIMEOUT_CYCLES = 16). A memory responder acks after a
// programmable number of wait states; every done is checked against the
// expected-transaction queue filled when stimulus is driven.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset, if_req, d_req, d_we, mem_ack;
  logic [63:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, perf_if_wait, perf_d_wait;
  logic [63:0] d_rdata, mem_addr, mem_wdata;
  logic        if_done, d_done, err, mem_req, mem_we, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_d;
    bit          we;
    bit          err;
    logic [63:0] addr;
    logic [63:0] rdata;
  } exp_t;
  exp_t sb[$];

  int          resp_mode = 0;    // 0: ack after wait_states, 1: never ack
  int          wait_states = 0;
  int          wcnt = 0;
  bit          manual_ack = 1'b0;
  bit          prev_req = 1'b0;
  logic [63:0] g_addr = '0;
  bit          g_we = 1'b0;
  logic [63:0] model_d = '0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
    .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    case (a)
      64'h40:  return 64'h0000_0000_00A0_0093;
      64'h100: return 64'hDEAD_BEEF_CAFE_F00D;
      default: return a ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input bit is_d, input bit we, input bit e,
                            input logic [63:0] addr, input logic [63:0] rdata);
    exp_t t;
    t.is_d = is_d; t.we = we; t.err = e; t.addr = addr; t.rdata = rdata;
    sb.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_d, input int budget, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (is_d ? d_done : if_done) begin
        seen = 1'b1;
        if (is_d) d_req = 1'b0;
        else      if_req = 1'b0;
      end
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  // Memory responder: drives mem_ack/mem_rdata on the falling edge.
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (resp_mode == 0) begin
      if (wcnt == wait_states) begin
        mem_ack = 1'b1;
        mem_rdata = mem_model(mem_addr);
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
    end
    if (manual_ack) begin
      mem_ack = 1'b1;
      mem_rdata = 64'h1234_5678_9ABC_DEF0;
    end
  end

  // Scoreboard monitor: records each grant, checks each done against the queue.
  always @(negedge clk) begin
    if (reset) model_d = '0;
    if (mem_req && !prev_req) begin
      g_addr = mem_addr;
      g_we   = mem_we;
    end
    prev_req = mem_req;
    if (if_done || d_done) begin
      chk("done_exclusive", 64'(if_done & d_done), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", {62'd0, if_done, d_done}, 64'd0);
      end else begin
        exp_t e;
        logic [63:0] exp_rd;
        e = sb.pop_front();
        chk("done_kind", 64'(d_done), 64'(e.is_d));
        chk("grant_addr", g_addr, e.addr);
        chk("grant_we", 64'(g_we), 64'(e.we));
        chk("done_err", 64'(err), 64'(e.err));
        if (e.is_d) begin
          exp_rd = (e.we && !e.err) ? model_d : e.rdata;
          chk("d_rdata", d_rdata, exp_rd);
          model_d = exp_rd;
        end else begin
          chk("if_rdata", 64'(if_rdata), {32'd0, e.rdata[31:0]});
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt, d_before_if, hi;
    bit if_seen, ended;

    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dones", {61'd0, if_done, d_done, err}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_we_wdata", mem_wdata | 64'(mem_we), 64'd0);
    chk("rst_rdata", d_rdata | 64'(if_rdata), 64'd0);
    chk("rst_perf", 64'(perf_if_wait) | 64'(perf_d_wait), 64'd0);
    reset = 1'b0;
    step();

    // 1: lone fetch, zero wait; stale if_req held through the done cycle
    if_addr = 64'h40; if_req = 1'b1;
    expect_txn(1'b0, 1'b0, 1'b0, 64'h40, mem_model(64'h40));
    step();
    chk("t1_mem_req", 64'(mem_req), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_mem_wdata", mem_wdata, 64'd0);
    step();
    chk("t1_if_done", 64'(if_done), 64'd1);
    chk("t1_mem_req_drop", 64'(mem_req), 64'd0);
    chk("t1_if_rdata", 64'(if_rdata), 64'h00A0_0093);
    chk("t1_err", 64'(err), 64'd0);
    step();
    chk("t1_stale_masked", 64'(mem_req), 64'd0);
    chk("t1_done_one_cycle", 64'(if_done), 64'd0);
    if_req = 1'b0;
    step();

    // 2: simultaneous fetch and load, data first
    d_addr = 64'h100; d_we = 1'b0; d_req = 1'b1;
    if_addr = 64'h44; if_req = 1'b1;
    expect_txn(1'b1, 1'b0, 1'b0, 64'h100, mem_model(64'h100));
    expect_txn(1'b0, 1'b0, 1'b0, 64'h44, mem_model(64'h44));
    step();
    chk("t2_first_addr", mem_addr, 64'h100);
    wait_done(1'b1, 10, "t2_d_done_seen");
    chk("t2_d_rdata", d_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    wait_done(1'b0, 10, "t2_if_done_seen");
    step();

    // 3: starvation guard; fetch retracts only in data-done cycles
    d_addr = 64'h300; d_we = 1'b0; if_addr = 64'h80;
    for (int k = 0; k < 4; k++)
      expect_txn(1'b1, 1'b0, 1'b0, 64'h300, mem_model(64'h300));
    expect_txn(1'b0, 1'b0, 1'b0, 64'h80, mem_model(64'h80));
    expect_txn(1'b1, 1'b0, 1'b0, 64'h300, mem_model(64'h300));
    dcnt = 0; d_before_if = -1; if_seen = 1'b0;
    d_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (d_done) begin
        dcnt++;
        if (if_seen) begin
          d_req = 1'b0;
          break;
        end
        if_req = 1'b0;
      end else if (if_done) begin
        if_seen = 1'b1;
        if_req = 1'b0;
        d_before_if = dcnt;
      end else if (!if_seen) begin
        if_req = 1'b1;
      end
    end
    chk("t3_data_before_fetch", 64'(d_before_if), 64'd4);
    chk("t3_total_data", 64'(dcnt), 64'd5);
    d_req = 1'b0; if_req = 1'b0;
    step();

    // 4: store timeout
    resp_mode = 1;
    d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'h1122_3344_5566_7788; d_req = 1'b1;
    expect_txn(1'b1, 1'b1, 1'b1, 64'h200, 64'd0);
    hi = 0; ended = 1'b0;
    for (int i = 0; i < 40 && !ended; i++) begin
      step();
      if (mem_req) begin
        hi++;
        if (hi == 1) chk("t4_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
      end else begin
        ended = 1'b1;
      end
    end
    chk("t4_req_cycles", 64'(hi), 64'd16);
    chk("t4_d_done_err", {62'd0, d_done, err}, 64'd3);
    chk("t4_d_rdata", d_rdata, 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    d_req = 1'b0;
    step();
    chk("t4_pulse_end", {62'd0, d_done, err}, 64'd0);
    resp_mode = 0;

    // 5: reset while serving a fetch; late ack ignored
    resp_mode = 1;
    if_addr = 64'h48; if_req = 1'b1;
    step();
    chk("t5_serving", {62'd0, mem_req, busy}, 64'd3);
    reset = 1'b1; if_req = 1'b0;
    step();
    chk("t5_reset_drop", {61'd0, mem_req, busy, if_done}, 64'd0);
    reset = 1'b0;
    step();
    manual_ack = 1'b1;
    step();
    manual_ack = 1'b0;
    step();
    chk("t5_no_done", {61'd0, if_done, d_done, busy}, 64'd0);
    step();
    resp_mode = 0;

    // 6: fetch waits behind a 3-wait-state store
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("t6_perf_cleared", 64'(perf_if_wait) | 64'(perf_d_wait), 64'd0);
    wait_states = 3;
    d_we = 1'b1; d_addr = 64'h208; d_wdata = 64'h0BAD_F00D_0000_0001; d_req = 1'b1;
    expect_txn(1'b1, 1'b1, 1'b0, 64'h208, 64'd0);
    expect_txn(1'b0, 1'b0, 1'b0, 64'h4C, mem_model(64'h4C));
    step(); step(); step();
    if_addr = 64'h4C; if_req = 1'b1;
    wait_done(1'b1, 20, "t6_d_done_seen");
    wait_done(1'b0, 20, "t6_if_done_seen");
    step();
`ifdef ARB_PERF_CNT_EN
    chk("t6_perf_if_wait", 64'(perf_if_wait), 64'd3);
    chk("t6_perf_d_wait", 64'(perf_d_wait), 64'd1);
`else
    chk("t6_perf_if_wait", 64'(perf_if_wait), 64'd0);
    chk("t6_perf_d_wait", 64'(perf_d_wait), 64'd0);
`endif
    wait_states = 0;
    step(); step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the pipeline's instruction-fetch (IF) and data-access (MEM) stages.
- Sequences one memory transaction at a time over a req/ack handshake with variable latency.
- Data accesses take priority, with a starvation guard for fetch and a bus timeout.
- Sits between the processor core's IF/MEM stages and the memory model.

Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while a fetch is pending (1..15).
- TIMEOUT_CYCLES, 16: cycles to wait for mem_ack before aborting; 0 disables the timeout (8-bit counter).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_done.
- if_addr  in  64  fetch address.
- if_rdata  out  32  fetched instruction, valid with if_done.
- if_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; d_we/d_addr/d_wdata held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  64  data address.
- d_wdata  in  64  store data.
- d_rdata  out  64  load data, valid with d_done.
- d_done  out  1  one-cycle completion pulse for data.
- err  out  1  pulses with a done pulse when that transaction timed out.
- mem_req  out  1  memory request, held until mem_ack or timeout.
- mem_we  out  1  memory write enable.
- mem_addr  out  64  memory address.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion; sampled only while mem_req = 1.
- busy  out  1  FSM is not in IDLE.
- perf_if_wait  out  32  fetch wait-cycle counter (optional feature).
- perf_d_wait  out  32  data wait-cycle counter (optional feature).

Behaviour:
- Reset: clk and reset only; reset is synchronous, active-high.
  - State = IDLE; streak counter and timeout counter = 0.
  - All outputs 0, including mem_*, rdata, done, err and busy.
  - Reset mid-transaction: mem_req drops at the same edge; no done pulse; any late mem_ack is ignored.
- FSM states: IDLE, SERVE_IF, SERVE_D. All outputs are registered.
- IDLE grant decision, made at each edge:
  - If d_req is set and NOT (if_req is set and streak = MAX_DATA_STREAK): go to SERVE_D.
  - Otherwise, if if_req is set: go to SERVE_IF.
  - Otherwise: stay in IDLE.
- On grant: mem_req, mem_we, mem_addr and mem_wdata are loaded at that edge. For fetch, mem_we = 0 and mem_wdata = 0.
- Streak counter:
  - On a data grant with if_req = 1: streak increments, saturating at MAX_DATA_STREAK.
  - On a data grant with if_req = 0, or on any fetch grant: streak clears to 0.
- SERVE state, edge with mem_ack = 1:
  - Capture the result: if_rdata = mem_rdata[31:0], or d_rdata = mem_rdata. A store leaves d_rdata unchanged.
  - Pulse the matching done for one cycle; drop mem_req; return to IDLE.
- SERVE state, edge with mem_ack = 0: the timeout counter increments.
  - If TIMEOUT_CYCLES ≠ 0 and the count reaches TIMEOUT_CYCLES: drop mem_req, pulse done and err, set the result to 0, return to IDLE.
- The timeout counter clears on each grant.
- Latency: request seen at edge N → mem_req high after N.
  - Zero-wait ack → done high after N+1.
  - Maximum throughput is one access per 2 cycles.
- Done cycle: FSM is in IDLE and may grant the next request. The just-completed requester's req is masked for that one cycle, so it is not re-served on a stale request.
- Simultaneous if_req and d_req in IDLE: data wins unless the streak limit is hit.
- A req dropped before its grant is legal and ignored. A req dropped while being served is a protocol violation: the transaction still completes.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - perf_if_wait increments each cycle that if_req = 1 and the FSM is not in SERVE_IF.
  - perf_d_wait increments likewise for d_req and SERVE_D.
  - Both are 32-bit, saturating, and cleared by reset.
- When undefined: both ports are driven constant 0 and no counter logic is built.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encoding typedef: IDLE = 2'd0, SERVE_IF = 2'd1, SERVE_D = 2'd2.
  - Width constants ADDR_W = 64, DATA_W = 64, INSTR_W = 32.
- One natural sub-module: arb_wait_timer, the clearable, saturating timeout counter with a terminal-count flag. The core also reuses it (32-bit) for the perf counters.

Test Plan:
1. Fetch only: if_req = 1, if_addr = 0x40, memory returns 0x00A00093 with zero wait → mem_req one cycle, if_done one cycle later, if_rdata = 0x00A00093, err = 0.
2. Simultaneous requests: if_req plus d_req (load at 0x100, memory returns 0xDEADBEEF_CAFEF00D) → data served first, then fetch. d_rdata = 0xDEADBEEFCAFEF00D.
3. Starvation guard: d_req held high with back-to-back loads while if_req = 1, MAX_DATA_STREAK = 4 → exactly 4 data dones, then if_done, then data resumes.
4. Timeout: d_req store, mem_ack never asserted, TIMEOUT_CYCLES = 16 → mem_req high exactly 16 cycles, then d_done = err = 1 for one cycle, d_rdata = 0, FSM returns to IDLE.
5. Reset mid-transaction: reset asserted while in SERVE_IF with mem_req = 1 → next edge mem_req = 0, busy = 0, no if_done; an ack two cycles later produces no done.
6. ARB_PERF_CNT_EN defined: fetch waits 3 cycles behind a 3-wait-state store → perf_if_wait = 3 after completion; with the macro undefined, both perf ports stay 0.
